axi_read_data_router: RTL and testbench

- Return-path router for the AXI read-data (R) channel in the interconnect.
- Collects R beats from slaves S0..S5 (ROM, IM, DM, DMA, WDT, DRAM) and steers each burst to master M0, M1 or M2.
- The target master is decoded from the upper tag field of the slave-side RID.
- A round-robin arbiter picks one slave at a time and holds that grant until the RLAST handshake, so bursts never interleave.

---
 rtl/axi_rd_pkg.sv | 33 +++
 rtl/rr_arbiter6.sv | 28 ++
 rtl/axi_read_data_router.sv | 209 ++++++++++++++++++++
 tb/tb_axi_read_data_router.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_pkg.sv
// Shared types and constants for the AXI read-data return path.
// Pulled in by the R-channel router and its round-robin arbiter.
package axi_rd_pkg;

    localparam int unsigned NUM_SLAVES  = 6;
    localparam int unsigned NUM_MASTERS = 3;

    localparam int unsigned R_DATA_W = 32;
    localparam int unsigned R_IDS_W  = 8;
    localparam int unsigned R_ID_W   = 4;

    localparam logic [R_IDS_W-R_ID_W-1:0] TAG_M0 = 4'b0001;
    localparam logic [R_IDS_W-R_ID_W-1:0] TAG_M1 = 4'b0010;
    localparam logic [R_IDS_W-R_ID_W-1:0] TAG_M2 = 4'b0100;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    typedef struct packed {
        logic [R_IDS_W-1:0]  rid;
        logic [R_DATA_W-1:0] rdata;
        logic [1:0]          rresp;
        logic                rlast;
    } r_beat_t;

    // Slave index successor with wrap 5 -> 0.
    function automatic logic [2:0] next_slave(input logic [2:0] idx);
        return (idx >= 3'(NUM_SLAVES - 1)) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter6.sv
// Combinational round-robin pick among six requesters, starting the scan at ptr.
// Shared between the read-data and write-response routers.
module rr_arbiter6
    import axi_rd_pkg::*;
(
    input  logic [5:0] req,
    input  logic [2:0] ptr,
    output logic [2:0] winner,
    output logic       any
);

    logic [2:0] idx;

    always_comb begin
        winner = 3'd0;
        any    = 1'b0;
        // Pointer values 6 and 7 are never produced; fold them onto 0 defensively.
        idx    = (ptr >= 3'(NUM_SLAVES)) ? 3'd0 : ptr;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
            idx = next_slave(idx);
        end
    end

endmodule

// File: rtl/axi_read_data_router.sv
// AXI R-channel return router: six slaves to three masters, burst-locked round robin,
// zero-latency combinational forwarding, beats with unknown tags drained and flagged.
module axi_read_data_router
    import axi_rd_pkg::*;
#(
    parameter int unsigned DATA_W = R_DATA_W,
    parameter int unsigned IDS_W  = R_IDS_W,
    parameter int unsigned ID_W   = R_ID_W,
    parameter logic [IDS_W-ID_W-1:0] M0_TAG = TAG_M0,
    parameter logic [IDS_W-ID_W-1:0] M1_TAG = TAG_M1,
    parameter logic [IDS_W-ID_W-1:0] M2_TAG = TAG_M2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDS_W-1:0]  RID_S0,
    input  logic [IDS_W-1:0]  RID_S1,
    input  logic [IDS_W-1:0]  RID_S2,
    input  logic [IDS_W-1:0]  RID_S3,
    input  logic [IDS_W-1:0]  RID_S4,
    input  logic [IDS_W-1:0]  RID_S5,
    input  logic [DATA_W-1:0] RDATA_S0,
    input  logic [DATA_W-1:0] RDATA_S1,
    input  logic [DATA_W-1:0] RDATA_S2,
    input  logic [DATA_W-1:0] RDATA_S3,
    input  logic [DATA_W-1:0] RDATA_S4,
    input  logic [DATA_W-1:0] RDATA_S5,
    input  logic [1:0]        RRESP_S0,
    input  logic [1:0]        RRESP_S1,
    input  logic [1:0]        RRESP_S2,
    input  logic [1:0]        RRESP_S3,
    input  logic [1:0]        RRESP_S4,
    input  logic [1:0]        RRESP_S5,
    input  logic              RLAST_S0,
    input  logic              RLAST_S1,
    input  logic              RLAST_S2,
    input  logic              RLAST_S3,
    input  logic              RLAST_S4,
    input  logic              RLAST_S5,
    input  logic              RVALID_S0,
    input  logic              RVALID_S1,
    input  logic              RVALID_S2,
    input  logic              RVALID_S3,
    input  logic              RVALID_S4,
    input  logic              RVALID_S5,
    output logic              RREADY_S0,
    output logic              RREADY_S1,
    output logic              RREADY_S2,
    output logic              RREADY_S3,
    output logic              RREADY_S4,
    output logic              RREADY_S5,
    output logic [ID_W-1:0]   RID_M0,
    output logic [ID_W-1:0]   RID_M1,
    output logic [ID_W-1:0]   RID_M2,
    output logic [DATA_W-1:0] RDATA_M0,
    output logic [DATA_W-1:0] RDATA_M1,
    output logic [DATA_W-1:0] RDATA_M2,
    output logic [1:0]        RRESP_M0,
    output logic [1:0]        RRESP_M1,
    output logic [1:0]        RRESP_M2,
    output logic              RLAST_M0,
    output logic              RLAST_M1,
    output logic              RLAST_M2,
    output logic              RVALID_M0,
    output logic              RVALID_M1,
    output logic              RVALID_M2,
    input  logic              RREADY_M0,
    input  logic              RREADY_M1,
    input  logic              RREADY_M2,
    output logic              drop_err
);

    state_e     state_q;
    logic [2:0] gnt_q;
    logic [2:0] rr_ptr_q;
    logic       drop_err_q;

    r_beat_t                  s_beat [NUM_SLAVES];
    logic [NUM_SLAVES-1:0]    s_valid;
    logic [NUM_SLAVES-1:0]    s_ready;
    logic [NUM_MASTERS-1:0]   m_ready;
    logic [NUM_MASTERS-1:0]   m_valid;
    logic [ID_W-1:0]          m_rid   [NUM_MASTERS];
    logic [DATA_W-1:0]        m_rdata [NUM_MASTERS];
    logic [1:0]               m_rresp [NUM_MASTERS];
    logic [NUM_MASTERS-1:0]   m_rlast;

    logic [2:0]               winner;
    logic                     any;
    logic [2:0]               sel;
    logic                     sel_active;
    logic                     sel_valid;
    r_beat_t                  beat;
    logic [IDS_W-ID_W-1:0]    tag;
    logic [NUM_MASTERS-1:0]   hit;
    logic                     known;
    logic                     hs;

    assign s_beat[0] = '{rid: RID_S0, rdata: RDATA_S0, rresp: RRESP_S0, rlast: RLAST_S0};
    assign s_beat[1] = '{rid: RID_S1, rdata: RDATA_S1, rresp: RRESP_S1, rlast: RLAST_S1};
    assign s_beat[2] = '{rid: RID_S2, rdata: RDATA_S2, rresp: RRESP_S2, rlast: RLAST_S2};
    assign s_beat[3] = '{rid: RID_S3, rdata: RDATA_S3, rresp: RRESP_S3, rlast: RLAST_S3};
    assign s_beat[4] = '{rid: RID_S4, rdata: RDATA_S4, rresp: RRESP_S4, rlast: RLAST_S4};
    assign s_beat[5] = '{rid: RID_S5, rdata: RDATA_S5, rresp: RRESP_S5, rlast: RLAST_S5};

    assign s_valid = {RVALID_S5, RVALID_S4, RVALID_S3, RVALID_S2, RVALID_S1, RVALID_S0};
    assign m_ready = {RREADY_M2, RREADY_M1, RREADY_M0};

    rr_arbiter6 u_arb (
        .req    (s_valid),
        .ptr    (rr_ptr_q),
        .winner (winner),
        .any    (any)
    );

    always_comb begin
        sel        = (state_q == BURST) ? gnt_q : winner;
        sel_active = (state_q == BURST) || any;
        beat       = s_beat[sel];
        sel_valid  = s_valid[sel];
        tag        = beat.rid[IDS_W-1:ID_W];
        hit        = {tag == M2_TAG, tag == M1_TAG, tag == M0_TAG};
        known      = |hit;

        s_ready = '0;
        m_valid = '0;
        m_rlast = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            m_rid[m]   = '0;
            m_rdata[m] = '0;
            m_rresp[m] = '0;
        end

        if (sel_active) begin
            // Unknown tags are drained so a misrouted slave can never wedge the interconnect.
            if (!known) begin
                s_ready[sel] = 1'b1;
            end
            for (int m = 0; m < NUM_MASTERS; m++) begin
                if (hit[m]) begin
                    m_valid[m]   = sel_valid;
                    m_rid[m]     = beat.rid[ID_W-1:0];
                    m_rdata[m]   = beat.rdata;
                    m_rresp[m]   = beat.rresp;
                    m_rlast[m]   = beat.rlast;
                    s_ready[sel] = m_ready[m];
                end
            end
        end

        hs = sel_active && sel_valid && s_ready[sel];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 3'd0;
            rr_ptr_q   <= 3'd0;
            drop_err_q <= 1'b0;
        end else begin
            drop_err_q <= hs && !known;
            case (state_q)
                IDLE: begin
                    if (any) begin
                        if (hs && beat.rlast) begin
                            rr_ptr_q <= next_slave(winner);
                        end else begin
                            state_q <= BURST;
                            gnt_q   <= winner;
                        end
                    end
                end
                BURST: begin
                    if (hs && beat.rlast) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= next_slave(gnt_q);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs are forced low while rst is high so reset takes effect without a clock edge.
    assign RREADY_S0 = !rst && s_ready[0];
    assign RREADY_S1 = !rst && s_ready[1];
    assign RREADY_S2 = !rst && s_ready[2];
    assign RREADY_S3 = !rst && s_ready[3];
    assign RREADY_S4 = !rst && s_ready[4];
    assign RREADY_S5 = !rst && s_ready[5];

    assign RVALID_M0 = !rst && m_valid[0];
    assign RVALID_M1 = !rst && m_valid[1];
    assign RVALID_M2 = !rst && m_valid[2];
    assign RLAST_M0  = !rst && m_rlast[0];
    assign RLAST_M1  = !rst && m_rlast[1];
    assign RLAST_M2  = !rst && m_rlast[2];
    assign RID_M0    = rst ? '0 : m_rid[0];
    assign RID_M1    = rst ? '0 : m_rid[1];
    assign RID_M2    = rst ? '0 : m_rid[2];
    assign RDATA_M0  = rst ? '0 : m_rdata[0];
    assign RDATA_M1  = rst ? '0 : m_rdata[1];
    assign RDATA_M2  = rst ? '0 : m_rdata[2];
    assign RRESP_M0  = rst ? '0 : m_rresp[0];
    assign RRESP_M1  = rst ? '0 : m_rresp[1];
    assign RRESP_M2  = rst ? '0 : m_rresp[2];

    assign drop_err = drop_err_q;

endmodule

// File: tb/tb_axi_read_data_router.sv
// Directed bench for axi_read_data_router: stimulus queues expected master beats,
// a negedge monitor pops and compares every handshake the DUT presents.
module tb_axi_read_data_router;
    import axi_rd_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rid_s   [6];
    logic [31:0] rdata_s [6];
    logic [1:0]  rresp_s [6];
    logic [5:0]  rlast_s;
    logic [5:0]  rvalid_s;
    logic [5:0]  rready_s;
    logic [3:0]  rid_m   [3];
    logic [31:0] rdata_m [3];
    logic [1:0]  rresp_m [3];
    logic [2:0]  rlast_m;
    logic [2:0]  rvalid_m;
    logic [2:0]  rready_m;
    logic        drop_err;

    typedef struct {
        int          m;
        logic [3:0]  rid;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   exp_drops  = 0;
    int   seen_drops = 0;

    always #5 clk = ~clk;

    axi_read_data_router dut (
        .clk       (clk),
        .rst       (rst),
        .RID_S0    (rid_s[0]),   .RID_S1    (rid_s[1]),   .RID_S2    (rid_s[2]),
        .RID_S3    (rid_s[3]),   .RID_S4    (rid_s[4]),   .RID_S5    (rid_s[5]),
        .RDATA_S0  (rdata_s[0]), .RDATA_S1  (rdata_s[1]), .RDATA_S2  (rdata_s[2]),
        .RDATA_S3  (rdata_s[3]), .RDATA_S4  (rdata_s[4]), .RDATA_S5  (rdata_s[5]),
        .RRESP_S0  (rresp_s[0]), .RRESP_S1  (rresp_s[1]), .RRESP_S2  (rresp_s[2]),
        .RRESP_S3  (rresp_s[3]), .RRESP_S4  (rresp_s[4]), .RRESP_S5  (rresp_s[5]),
        .RLAST_S0  (rlast_s[0]), .RLAST_S1  (rlast_s[1]), .RLAST_S2  (rlast_s[2]),
        .RLAST_S3  (rlast_s[3]), .RLAST_S4  (rlast_s[4]), .RLAST_S5  (rlast_s[5]),
        .RVALID_S0 (rvalid_s[0]), .RVALID_S1 (rvalid_s[1]), .RVALID_S2 (rvalid_s[2]),
        .RVALID_S3 (rvalid_s[3]), .RVALID_S4 (rvalid_s[4]), .RVALID_S5 (rvalid_s[5]),
        .RREADY_S0 (rready_s[0]), .RREADY_S1 (rready_s[1]), .RREADY_S2 (rready_s[2]),
        .RREADY_S3 (rready_s[3]), .RREADY_S4 (rready_s[4]), .RREADY_S5 (rready_s[5]),
        .RID_M0    (rid_m[0]),   .RID_M1    (rid_m[1]),   .RID_M2    (rid_m[2]),
        .RDATA_M0  (rdata_m[0]), .RDATA_M1  (rdata_m[1]), .RDATA_M2  (rdata_m[2]),
        .RRESP_M0  (rresp_m[0]), .RRESP_M1  (rresp_m[1]), .RRESP_M2  (rresp_m[2]),
        .RLAST_M0  (rlast_m[0]), .RLAST_M1  (rlast_m[1]), .RLAST_M2  (rlast_m[2]),
        .RVALID_M0 (rvalid_m[0]), .RVALID_M1 (rvalid_m[1]), .RVALID_M2 (rvalid_m[2]),
        .RREADY_M0 (rready_m[0]), .RREADY_M1 (rready_m[1]), .RREADY_M2 (rready_m[2]),
        .drop_err  (drop_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic expect_beat(input int m, input logic [3:0] rid, input logic [31:0] data,
                               input logic [1:0] resp, input logic last);
        exp_t e;
        e.m = m; e.rid = rid; e.data = data; e.resp = resp; e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic drive(input int s, input logic [7:0] rid, input logic [31:0] data,
                         input logic [1:0] resp, input logic last);
        rid_s[s]    = rid;
        rdata_s[s]  = data;
        rresp_s[s]  = resp;
        rlast_s[s]  = last;
        rvalid_s[s] = 1'b1;
    endtask

    task automatic release_slave(input int s);
        rvalid_s[s] = 1'b0;
        rlast_s[s]  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every master-side handshake must match the next queued beat.
    always @(negedge clk) begin
        if (!rst) begin
            for (int m = 0; m < 3; m++) begin
                if (rvalid_m[m] && rready_m[m]) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat: master %0d data %0h, expected none",
                                 m, rdata_m[m]);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("beat_master", 64'(m), 64'(mon_e.m));
                        check("beat_rid", rid_m[m], mon_e.rid);
                        check("beat_data", rdata_m[m], mon_e.data);
                        check("beat_resp", rresp_m[m], mon_e.resp);
                        check("beat_last", rlast_m[m], mon_e.last);
                    end
                end
            end
            if (drop_err) seen_drops++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end by 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   ord [4];
        logic [2:0] gnt_seen;
        for (int s = 0; s < 6; s++) begin
            rid_s[s]   = 8'h00;
            rdata_s[s] = 32'h0;
            rresp_s[s] = 2'b00;
        end
        rlast_s  = '0;
        rvalid_s = '0;
        rready_m = 3'b111;

        // Reset: outputs held low even with a valid slave present.
        #3;
        drive(0, 8'h10, 32'h5555_0000, 2'b00, 1'b1);
        #1;
        check("rst_rvalid_m", rvalid_m, 3'b000);
        check("rst_rready_s", rready_s, 6'b000000);
        check("rst_rdata_m0", rdata_m[0], 32'h0);
        check("rst_drop_err", drop_err, 1'b0);
        release_slave(0);
        step();
        step();
        rst = 1'b0;
        check("rst_rr_ptr", dut.rr_ptr_q, 3'd0);
        check("rst_state", dut.state_q, IDLE);

        // Single beat S2 -> M1.
        drive(2, 8'h23, 32'hDEAD_BEEF, 2'b00, 1'b1);
        expect_beat(1, 4'h3, 32'hDEAD_BEEF, 2'b00, 1'b1);
        #1;
        check("single_rvalid_m", rvalid_m, 3'b010);
        check("single_rid_m1", rid_m[1], 4'h3);
        check("single_rready_s", rready_s, 6'b000100);
        step();
        release_slave(2);
        check("single_state", dut.state_q, IDLE);
        check("single_rr_ptr", dut.rr_ptr_q, 3'd3);

        // Four-beat S5 burst to M2 with a stall, a valid gap, and S1 waiting.
        drive(5, 8'h4A, 32'h0000_0001, 2'b00, 1'b0);
        expect_beat(2, 4'hA, 32'h0000_0001, 2'b00, 1'b0);
        #1;
        check("burst_b1_rready", rready_s, 6'b100000);
        step();
        drive(5, 8'h4A, 32'h0000_0002, 2'b01, 1'b0);
        rready_m[2] = 1'b0;
        drive(1, 8'h15, 32'h1111_1111, 2'b00, 1'b1);
        #1;
        check("burst_stall_rvalid", rvalid_m, 3'b100);
        check("burst_stall_rready", rready_s, 6'b000000);
        check("burst_stall_gnt", dut.gnt_q, 3'd5);
        step();
        rready_m[2] = 1'b1;
        expect_beat(2, 4'hA, 32'h0000_0002, 2'b01, 1'b0);
        #1;
        check("burst_b2_rready", rready_s, 6'b100000);
        step();
        release_slave(5);
        #1;
        check("burst_gap_rvalid", rvalid_m, 3'b000);
        check("burst_gap_rready", rready_s, 6'b100000);
        step();
        drive(5, 8'h4A, 32'h0000_0003, 2'b00, 1'b0);
        expect_beat(2, 4'hA, 32'h0000_0003, 2'b00, 1'b0);
        step();
        drive(5, 8'h4A, 32'h0000_0004, 2'b10, 1'b1);
        expect_beat(2, 4'hA, 32'h0000_0004, 2'b10, 1'b1);
        #1;
        check("burst_b4_rready", rready_s, 6'b100000);
        step();
        release_slave(5);
        expect_beat(0, 4'h5, 32'h1111_1111, 2'b00, 1'b1);
        #1;
        check("burst_s1_rvalid", rvalid_m, 3'b001);
        check("burst_s1_rready", rready_s, 6'b000010);
        step();
        release_slave(1);

        // Unknown tag from S1: drained, flagged one cycle later.
        drive(1, 8'h83, 32'h8383_8383, 2'b00, 1'b1);
        exp_drops++;
        #1;
        check("drop_rready", rready_s, 6'b000010);
        check("drop_rvalid_m", rvalid_m, 3'b000);
        step();
        release_slave(1);
        check("drop_err_hi", drop_err, 1'b1);
        step();
        check("drop_err_lo", drop_err, 1'b0);

        // Reset in the middle of an S2 burst.
        drive(2, 8'h17, 32'hA000_0001, 2'b00, 1'b0);
        expect_beat(0, 4'h7, 32'hA000_0001, 2'b00, 1'b0);
        step();
        drive(2, 8'h17, 32'hA000_0002, 2'b00, 1'b0);
        expect_beat(0, 4'h7, 32'hA000_0002, 2'b00, 1'b0);
        step();
        drive(2, 8'h17, 32'hA000_0003, 2'b00, 1'b0);
        #1;
        check("rstmid_pre_rvalid", rvalid_m, 3'b001);
        #1;
        rst = 1'b1;
        #1;
        check("rstmid_rvalid", rvalid_m, 3'b000);
        check("rstmid_rready", rready_s, 6'b000000);
        check("rstmid_drop", drop_err, 1'b0);
        check("rstmid_state", dut.state_q, IDLE);
        check("rstmid_rr_ptr", dut.rr_ptr_q, 3'd0);
        release_slave(2);
        step();
        rst = 1'b0;

        // Round robin with S0, S3, S4 continuously valid, single-beat bursts.
        ord = '{0, 3, 4, 0};
        drive(0, 8'h10, 32'h0000_00A0, 2'b00, 1'b1);
        drive(3, 8'h21, 32'h0000_00A3, 2'b11, 1'b1);
        drive(4, 8'h42, 32'h0000_00A4, 2'b00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            case (ord[i])
                0: expect_beat(0, 4'h0, 32'h0000_00A0, 2'b00, 1'b1);
                3: expect_beat(1, 4'h1, 32'h0000_00A3, 2'b11, 1'b1);
                default: expect_beat(2, 4'h2, 32'h0000_00A4, 2'b00, 1'b1);
            endcase
            #1;
            check("rr_rready", rready_s, 6'(1 << ord[i]));
            step();
        end
        release_slave(0);
        release_slave(3);
        release_slave(4);

        // Master back-pressure: M0 not ready for ten cycles.
        rready_m[0] = 1'b0;
        drive(0, 8'h1C, 32'hCAFE_F00D, 2'b01, 1'b0);
        for (int i = 0; i < 10; i++) begin
            #1;
            check("bp_stable", {rvalid_m, rdata_m[0], rready_s}, {3'b001, 32'hCAFE_F00D, 6'b0});
            step();
        end
        gnt_seen = dut.gnt_q;
        check("bp_gnt", gnt_seen, 3'd0);
        check("bp_state", dut.state_q, BURST);
        rready_m[0] = 1'b1;
        expect_beat(0, 4'hC, 32'hCAFE_F00D, 2'b01, 1'b0);
        step();
        drive(0, 8'h1C, 32'h0BAD_F00D, 2'b01, 1'b1);
        expect_beat(0, 4'hC, 32'h0BAD_F00D, 2'b01, 1'b1);
        step();
        release_slave(0);
        check("bp_end_state", dut.state_q, IDLE);

        step();
        step();
        check("sb_empty", 64'(exp_q.size()), 64'd0);
        check("drop_count", 64'(seen_drops), 64'(exp_drops));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
